cache_trace_driver: RTL

// - Synthesizable initiator for the cache-under-test address interface: replays a loadable address trace

---
 rtl/cache_sim_pkg.sv | 13 +
 rtl/cache_trace_driver_if.sv | 15 +
 rtl/cache_trace_mem.sv | 25 ++
 rtl/cache_trace_driver.sv | 130 +++++++++++++
 4 files changed

// File: rtl/cache_sim_pkg.sv
// Shared types and widths for the cache trace driver and the cache under test.
package cache_sim_pkg;

    localparam int unsigned CACHE_ADDR_W = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/cache_trace_driver_if.sv
// Address/hit link between the trace driver (master) and the cache under test (slave).
interface cache_trace_driver_if
    import cache_sim_pkg::*;
#(
    parameter int unsigned ADDR_W = CACHE_ADDR_W
) ();

    logic [ADDR_W-1:0] cache_addr;
    logic              cache_req;
    logic              cache_hit;

    modport master (output cache_addr, output cache_req, input cache_hit);
    modport slave  (input cache_addr, input cache_req, output cache_hit);

endinterface

// File: rtl/cache_trace_mem.sv
// Trace register file: synchronous write, asynchronous read, contents survive reset.
module cache_trace_mem #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 11,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [ADDR_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [ADDR_W-1:0] rd_data
);

    logic [ADDR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/cache_trace_driver.sv
// Replays a loaded address trace into a cache, one address per cycle, and
// counts the hits/misses the cache reports HIT_LAT cycles later.
module cache_trace_driver
    import cache_sim_pkg::*;
#(
    parameter int unsigned ADDR_W  = CACHE_ADDR_W,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned HIT_LAT = 1,
    localparam int unsigned IDX_W  = $clog2(DEPTH),
    localparam int unsigned LEN_W  = IDX_W + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_en,
    input  logic [IDX_W-1:0]     load_idx,
    input  logic [ADDR_W-1:0]    load_addr,
    input  logic [LEN_W-1:0]     trace_len,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     hit_cnt,
    output logic [CNT_W-1:0]     miss_cnt,
    cache_trace_driver_if.master cif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   len_clamped;
    logic [HIT_LAT-1:0] pend;
    logic [HIT_LAT-1:0] pend_next;
    logic [ADDR_W-1:0]  rd_data;
    logic               req;
    logic               mem_we;
    logic               sample;
    logic               last_issue;

    assign len_clamped = (trace_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : trace_len;
    assign mem_we      = load_en && (state == ST_IDLE);
    assign last_issue  = (LEN_W'(idx) == (len - LEN_W'(1)));

    // cache_req itself is stage 0 of the valid pipe; pend holds the remaining HIT_LAT stages
    assign pend_next = HIT_LAT'({pend, req});
    assign sample    = pend[HIT_LAT-1];

    assign cif.cache_req  = req;
    assign cif.cache_addr = req ? rd_data : '0;

    cache_trace_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .we      (mem_we),
        .wr_idx  (load_idx),
        .wr_data (load_addr),
        .rd_idx  (idx),
        .rd_data (rd_data)
    );

    // Sequencer, sampling pipe and saturating counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            req      <= 1'b0;
            idx      <= '0;
            len      <= '0;
            pend     <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            pend <= pend_next;
            done <= 1'b0;

            if (sample) begin
                if (cif.cache_hit) begin
                    if (hit_cnt != CNT_MAX) hit_cnt <= hit_cnt + CNT_W'(1);
                end else begin
                    if (miss_cnt != CNT_MAX) miss_cnt <= miss_cnt + CNT_W'(1);
                end
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        hit_cnt  <= '0;
                        miss_cnt <= '0;
                        idx      <= '0;
                        if (len_clamped != '0) begin
                            len   <= len_clamped;
                            state <= ST_ISSUE;
                            busy  <= 1'b1;
                            req   <= 1'b1;
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    idx <= idx + IDX_W'(1);
                    if (last_issue) begin
                        state <= ST_DRAIN;
                        req   <= 1'b0;
                    end
                end
                // Leave once the final outstanding request is being sampled at this edge
                ST_DRAIN: begin
                    if (pend_next == '0) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
